// File: rtl/pkt_rx_buffer.sv
// Ingress packet buffer. Complete, valid packets from the capture MAC are stored
// in a byte RAM and their lengths are queued in a descriptor FIFO. A start pulse
// from the downstream controller replays the head packet one byte per cycle.
module pkt_rx_buffer #(
  parameter int DATA_DEPTH  = 4096,
  parameter int LEN_DEPTH   = 16,
  parameter int MIN_PKT_LEN = 60,
  parameter int MAX_PKT_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic        rx_err,
  input  logic        rd_ctrl,
  output logic        new_request,
  output logic        pkt_valid,
  output logic [7:0]  pkt_data,
  output logic        pkt_last,
  output logic [10:0] pkt_len,
  output logic [15:0] drop_cnt
);

  localparam int AW  = $clog2(DATA_DEPTH);
  localparam int PW  = AW + 1;
  localparam int LAW = $clog2(LEN_DEPTH);
  localparam int LPW = LAW + 1;
  localparam logic [PW-1:0]  PTR_ONE_C  = PW'(1);
  localparam logic [PW-1:0]  DEPTH_C    = PW'(DATA_DEPTH);
  localparam logic [LPW-1:0] LPTR_ONE_C = LPW'(1);
  localparam logic [LPW-1:0] LDEPTH_C   = LPW'(LEN_DEPTH);
  localparam logic [10:0]    MIN_LEN_C  = 11'(MIN_PKT_LEN);
  localparam logic [10:0]    MAX_LEN_C  = 11'(MAX_PKT_LEN);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_RECV = 2'd1, W_DROP = 2'd2} wstate_e;
  typedef enum logic       {R_IDLE = 1'b0, R_STREAM = 1'b1} rstate_e;

  // Storage (no reset: contents are only meaningful behind the pointers)
  logic [7:0]  mem_r    [DATA_DEPTH];
  logic [10:0] lf_mem_r [LEN_DEPTH];
  logic [7:0]  rd_data_r;

  // Write side
  wstate_e       wstate_r, wstate_nxt_s;
  logic [PW-1:0] wr_ptr_r, wr_ptr_nxt_s, commit_ptr_r, commit_nxt_s, base_wr_s;
  logic [10:0]   len_r, len_nxt_s, base_len_s, new_len_s;
  logic          pkt_byte_s, abort_s, drop_pkt_s, full_s, mem_we_s, push_s;
  logic [AW-1:0] mem_waddr_s;
  logic [1:0]    drop_inc_s;
  logic [16:0]   drop_sum_s;
  logic [15:0]   drop_cnt_r;

  // Descriptor FIFO
  logic [LPW-1:0] lf_wr_r, lf_rd_r;
  logic           lf_full_s, lf_empty_s;
  logic [10:0]    lf_head_s;

  // Read side
  rstate_e       rstate_r, rstate_nxt_s;
  logic [PW-1:0] rd_ptr_r;
  logic [10:0]   rd_cnt_r, pkt_len_r;
  logic          pop_s, fetch_s;
  logic          rd_vld_r, rd_last_r;
  logic          pkt_valid_r, pkt_last_r, new_request_r;
  logic [7:0]    pkt_data_r;

  assign lf_empty_s = (lf_wr_r == lf_rd_r);
  assign lf_full_s  = ((lf_wr_r - lf_rd_r) == LDEPTH_C);
  assign lf_head_s  = lf_mem_r[lf_rd_r[LAW-1:0]];

  // Write FSM next state: packet start/continue, abort, overflow and commit decisions
  always_comb begin
    wstate_nxt_s = wstate_r;
    wr_ptr_nxt_s = wr_ptr_r;
    commit_nxt_s = commit_ptr_r;
    len_nxt_s    = len_r;
    base_wr_s    = wr_ptr_r;
    base_len_s   = len_r;
    pkt_byte_s   = 1'b0;
    abort_s      = 1'b0;
    drop_pkt_s   = 1'b0;
    mem_we_s     = 1'b0;
    mem_waddr_s  = wr_ptr_r[AW-1:0];
    push_s       = 1'b0;
    if (rx_valid) begin
      case (wstate_r)
        W_IDLE: begin
          pkt_byte_s = rx_sop;
          base_len_s = 11'd0;
        end
        W_RECV: begin
          pkt_byte_s = 1'b1;
          if (rx_sop) begin
            // A new sop mid-packet abandons the partial packet and restarts
            abort_s    = 1'b1;
            base_wr_s  = commit_ptr_r;
            base_len_s = 11'd0;
          end else begin
            base_wr_s  = wr_ptr_r;
            base_len_s = len_r;
          end
        end
        W_DROP: begin
          pkt_byte_s = rx_sop;
          base_len_s = 11'd0;
          if (rx_eop && !rx_sop) begin
            wstate_nxt_s = W_IDLE;
          end else begin
            wstate_nxt_s = wstate_r;
          end
        end
        default: begin
          pkt_byte_s   = 1'b0;
          wstate_nxt_s = W_IDLE;
        end
      endcase
    end else begin
      pkt_byte_s = 1'b0;
    end
    new_len_s = base_len_s + 11'd1;
    full_s    = ((base_wr_s - rd_ptr_r) == DEPTH_C);
    if (pkt_byte_s) begin
      if (full_s || (base_len_s == MAX_LEN_C)) begin
        drop_pkt_s   = 1'b1;
        wr_ptr_nxt_s = commit_ptr_r;
        len_nxt_s    = 11'd0;
        wstate_nxt_s = rx_eop ? W_IDLE : W_DROP;
      end else begin
        mem_we_s    = 1'b1;
        mem_waddr_s = base_wr_s[AW-1:0];
        if (rx_eop) begin
          if (!rx_err && (new_len_s >= MIN_LEN_C) && (new_len_s <= MAX_LEN_C) && !lf_full_s) begin
            push_s       = 1'b1;
            wr_ptr_nxt_s = base_wr_s + PTR_ONE_C;
            commit_nxt_s = base_wr_s + PTR_ONE_C;
          end else begin
            drop_pkt_s   = 1'b1;
            wr_ptr_nxt_s = commit_ptr_r;
          end
          len_nxt_s    = 11'd0;
          wstate_nxt_s = W_IDLE;
        end else begin
          wr_ptr_nxt_s = base_wr_s + PTR_ONE_C;
          len_nxt_s    = new_len_s;
          wstate_nxt_s = W_RECV;
        end
      end
    end else begin
      mem_we_s = 1'b0;
    end
    drop_inc_s = {1'b0, abort_s} + {1'b0, drop_pkt_s};
    drop_sum_s = {1'b0, drop_cnt_r} + {15'd0, drop_inc_s};
  end

  // Write FSM, pointer, length and drop counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wstate_r     <= W_IDLE;
      wr_ptr_r     <= {PW{1'b0}};
      commit_ptr_r <= {PW{1'b0}};
      len_r        <= 11'd0;
      drop_cnt_r   <= 16'd0;
    end else begin
      wstate_r     <= wstate_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      commit_ptr_r <= commit_nxt_s;
      len_r        <= len_nxt_s;
      drop_cnt_r   <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end
  end

  // Byte RAM write port and registered read port
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= rx_data;
    end
    rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
  end

  // Descriptor FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      lf_mem_r[lf_wr_r[LAW-1:0]] <= new_len_s;
    end
  end

  // Descriptor FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lf_wr_r <= {LPW{1'b0}};
      lf_rd_r <= {LPW{1'b0}};
    end else begin
      if (push_s) lf_wr_r <= lf_wr_r + LPTR_ONE_C;
      if (pop_s)  lf_rd_r <= lf_rd_r + LPTR_ONE_C;
    end
  end

  // Read FSM next state: accept a replay request, stream until the counter runs out
  always_comb begin
    rstate_nxt_s = rstate_r;
    pop_s        = 1'b0;
    fetch_s      = 1'b0;
    case (rstate_r)
      R_IDLE: begin
        if (rd_ctrl && !lf_empty_s) begin
          pop_s        = 1'b1;
          rstate_nxt_s = R_STREAM;
        end else begin
          rstate_nxt_s = R_IDLE;
        end
      end
      R_STREAM: begin
        fetch_s = 1'b1;
        if (rd_cnt_r == 11'd1) begin
          rstate_nxt_s = R_IDLE;
        end else begin
          rstate_nxt_s = R_STREAM;
        end
      end
      default: rstate_nxt_s = R_IDLE;
    endcase
  end

  // Read FSM, replay pipeline and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate_r      <= R_IDLE;
      rd_ptr_r      <= {PW{1'b0}};
      rd_cnt_r      <= 11'd0;
      rd_vld_r      <= 1'b0;
      rd_last_r     <= 1'b0;
      pkt_len_r     <= 11'd0;
      pkt_valid_r   <= 1'b0;
      pkt_last_r    <= 1'b0;
      pkt_data_r    <= 8'h00;
      new_request_r <= 1'b0;
    end else begin
      rstate_r      <= rstate_nxt_s;
      new_request_r <= (rstate_r == R_IDLE) && !lf_empty_s;
      if (pop_s) begin
        pkt_len_r <= lf_head_s;
        rd_cnt_r  <= lf_head_s;
      end else if (fetch_s) begin
        rd_cnt_r <= rd_cnt_r - 11'd1;
      end
      if (fetch_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      rd_vld_r    <= fetch_s;
      rd_last_r   <= fetch_s && (rd_cnt_r == 11'd1);
      pkt_valid_r <= rd_vld_r;
      pkt_last_r  <= rd_last_r;
      if (rd_vld_r) begin
        pkt_data_r <= rd_data_r;
      end
    end
  end

  assign new_request = new_request_r;
  assign pkt_valid   = pkt_valid_r;
  assign pkt_data    = pkt_data_r;
  assign pkt_last    = pkt_last_r;
  assign pkt_len     = pkt_len_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_pkt_rx_buffer.sv
// Bench for pkt_rx_buffer: a table of single-packet cases plus hand-written
// sequences (FIFO overflow, mid-packet sop, reset during replay). Stored packets
// are pushed to a scoreboard when sent and popped when the DUT replays them.
module tb_pkt_rx_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_sop = 1'b0;
  logic        rx_eop = 1'b0;
  logic        rx_err = 1'b0;
  logic        rd_ctrl = 1'b0;
  logic        new_request;
  logic        pkt_valid;
  logic [7:0]  pkt_data;
  logic        pkt_last;
  logic [10:0] pkt_len;
  logic [15:0] drop_cnt;

  pkt_rx_buffer dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_err(rx_err),
    .rd_ctrl(rd_ctrl),
    .new_request(new_request), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .pkt_last(pkt_last), .pkt_len(pkt_len), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int len; bit err; logic [7:0] seed; bit keep; int drops; } vec_t;
  typedef struct { int len; logic [7:0] seed; } exp_t;

  vec_t tbl[9];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_drops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] seed, input bit err, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(seed + i);
      rx_sop   = (i == 0);
      rx_eop   = with_eop && (i == n - 1);
      rx_err   = err && with_eop && (i == n - 1);
      tick();
    end
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic replay_check(input string tag);
    exp_t e;
    int   lat;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    rd_ctrl = 1'b1;
    tick();
    rd_ctrl = 1'b0;
    check({tag, "_len"}, 64'(pkt_len), 64'(e.len));
    lat = 0;
    while (pkt_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd2);
    if (lat >= 8) return;
    for (int i = 0; i < e.len; i++) begin
      check({tag, "_byte"}, {61'd0, pkt_valid, pkt_last, 2'b00} << 8 | 64'(pkt_data),
            {61'd0, 1'b1, (i == e.len - 1), 2'b00} << 8 | 64'(8'(e.seed + i)));
      tick();
    end
    check({tag, "_tail_idle"}, 64'(pkt_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int cyc;
    tbl[0] = '{64,   1'b0, 8'h00, 1'b1, 0};
    tbl[1] = '{64,   1'b1, 8'h40, 1'b0, 1};
    tbl[2] = '{59,   1'b0, 8'h80, 1'b0, 1};
    tbl[3] = '{60,   1'b0, 8'h11, 1'b1, 0};
    tbl[4] = '{1518, 1'b0, 8'h22, 1'b1, 0};
    tbl[5] = '{1519, 1'b0, 8'h33, 1'b0, 1};
    tbl[6] = '{1600, 1'b0, 8'h44, 1'b0, 1};
    tbl[7] = '{100,  1'b0, 8'h55, 1'b1, 0};
    tbl[8] = '{1,    1'b0, 8'h66, 1'b0, 1};

    // Reset state
    repeat (3) tick();
    check("rst_new_request", 64'(new_request), 64'd0);
    check("rst_pkt_valid",   64'(pkt_valid),   64'd0);
    check("rst_pkt_last",    64'(pkt_last),    64'd0);
    check("rst_pkt_data",    64'(pkt_data),    64'd0);
    check("rst_pkt_len",     64'(pkt_len),     64'd0);
    check("rst_drop_cnt",    64'(drop_cnt),    64'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Table-driven single packets
    for (int k = 0; k < 9; k++) begin
      send_bytes(tbl[k].len, tbl[k].seed, tbl[k].err, 1'b1);
      check("tbl_nreq_early", 64'(new_request), 64'd0);
      tick();
      exp_drops += tbl[k].drops;
      check("tbl_nreq", 64'(new_request), 64'(tbl[k].keep));
      check("tbl_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
      if (tbl[k].keep) begin
        sb.push_back('{tbl[k].len, tbl[k].seed});
        replay_check("tbl");
        check("tbl_nreq_after", 64'(new_request), 64'd0);
      end
    end

    // 17 back-to-back minimum-length packets: descriptor FIFO holds 16
    for (int j = 0; j < 17; j++) begin
      send_bytes(60, 8'(j * 7), 1'b0, 1'b1);
      if (sb.size() < 16) sb.push_back('{60, 8'(j * 7)});
      else exp_drops++;
    end
    tick();
    check("fifo_full_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    for (int j = 0; j < 16; j++) begin
      check("fifo_nreq", 64'(new_request), 64'd1);
      replay_check("fifo");
    end
    tick();
    check("fifo_nreq_empty", 64'(new_request), 64'd0);

    // sop in the middle of a packet aborts it; only the new packet survives
    send_bytes(29, 8'hA0, 1'b0, 1'b0);
    send_bytes(80, 8'h10, 1'b0, 1'b1);
    exp_drops++;
    sb.push_back('{80, 8'h10});
    tick();
    check("abort_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    check("abort_nreq", 64'(new_request), 64'd1);
    replay_check("abort");
    tick();
    check("abort_nreq_after", 64'(new_request), 64'd0);

    // Reset during a replay
    send_bytes(100, 8'h77, 1'b0, 1'b1);
    tick();
    rd_ctrl = 1'b1;
    tick();
    rd_ctrl = 1'b0;
    nb = 0;
    cyc = 0;
    while (nb < 20 && cyc < 40) begin
      tick();
      cyc++;
      if (pkt_valid === 1'b1) nb++;
    end
    check("midrst_reach", 64'(nb), 64'd20);
    reset = 1'b0;
    #1;
    check("midrst_pkt_valid", 64'(pkt_valid), 64'd0);
    check("midrst_nreq", 64'(new_request), 64'd0);
    check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("postrst_nreq", 64'(new_request), 64'd0);
    rd_ctrl = 1'b1;
    tick();
    rd_ctrl = 1'b0;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pkt_valid !== 1'b0) nb++;
    end
    check("postrst_no_replay", 64'(nb), 64'd0);
    check("postrst_nreq_end", 64'(new_request), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
